// File: rtl/data_mem_responder_if.sv
// Purpose : request/response bundle between the MEM stage (requester) and the data-memory responder.
// Ports   : MemRead, MemWrite, DMControl, Address, WriteData from the requester;
//           ReadData, Ready, Busy, Error back from the responder.
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  DMControl;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Busy;
  logic        Error;

  modport master (
    output MemRead, MemWrite, DMControl, Address, WriteData,
    input  ReadData, Ready, Busy, Error
  );

  modport slave (
    input  MemRead, MemWrite, DMControl, Address, WriteData,
    output ReadData, Ready, Busy, Error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose : data-memory responder; accepts one load/store, waits WAIT_CYCLES, then completes it
//           against an internal word array with byte/half/word access and sign/zero extension.
// Ports   : Clk, reset (async active-low), bus (slave modport: request in, ReadData/Ready/Busy/Error out).
//           Ready arrives WAIT_CYCLES+1 cycles after acceptance; requester holds its request until Ready.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  state_t      nextState;

  logic [31:0] mem [DEPTH];

  // Request captured at acceptance
  logic        reqRd;
  logic        reqWr;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  waitCnt;

  // Registered outputs
  logic        readyR;
  logic        errorR;
  logic [31:0] readDataR;
  logic        busy;

  logic        reqIn;
  assign reqIn = bus.MemRead | bus.MemWrite;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (reqIn) nextState = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (waitCnt == 4'd1) nextState = ST_RESP;
      ST_RESP: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  // ---------------------------------------------------------------- request latch / wait counter
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      reqRd    <= 1'b0;
      reqWr    <= 1'b0;
      reqSize  <= 2'b00;
      reqAddr  <= 32'h0;
      reqWdata <= 32'h0;
      waitCnt  <= 4'd0;
    end else if (state == ST_IDLE && reqIn) begin
      reqRd    <= bus.MemRead;
      reqWr    <= bus.MemWrite;
      reqSize  <= bus.DMControl;
      reqAddr  <= bus.Address;
      reqWdata <= bus.WriteData;
      waitCnt  <= 4'(WAIT_CYCLES);
    end else if (state == ST_WAIT) begin
      waitCnt  <= waitCnt - 4'd1;
    end
  end

  // The response registers load on the edge that enters RESP. With zero wait
  // states that is the accepting edge itself, before the latch holds the
  // request, so the live inputs stand in for the latched copy while in IDLE.
  logic        effRd;
  logic        effWr;
  logic [1:0]  effSize;
  logic [31:0] effAddr;

  always_comb begin
    if (state == ST_IDLE) begin
      effRd   = bus.MemRead;
      effWr   = bus.MemWrite;
      effSize = bus.DMControl;
      effAddr = bus.Address;
    end else begin
      effRd   = reqRd;
      effWr   = reqWr;
      effSize = reqSize;
      effAddr = reqAddr;
    end
  end

  // ---------------------------------------------------------------- error detection
  logic badAlign;
  logic badRange;
  logic effErr;

  always_comb begin
    badAlign = 1'b0;
    case (effSize)
      2'b00:   badAlign = (effAddr[1:0] != 2'b00);
      2'b01:   badAlign = effAddr[0];
      default: badAlign = 1'b0;
    endcase
  end

  assign badRange = ({2'b00, effAddr[31:2]} >= 32'(DEPTH));
  assign effErr   = (effRd & effWr) | badAlign | badRange;

  // ---------------------------------------------------------------- load path
  logic [AW-1:0] rdIdx;
  logic [31:0]   rdWord;
  logic [7:0]    selByte;
  logic [15:0]   selHalf;
  logic [31:0]   loadVal;

  assign rdIdx  = effAddr[AW+1:2];
  assign rdWord = mem[rdIdx];

  always_comb begin
    selByte = rdWord[{effAddr[1:0], 3'b000} +: 8];
    selHalf = rdWord[{effAddr[1], 4'b0000} +: 16];
    case (effSize)
      2'b00:   loadVal = rdWord;
      2'b01:   loadVal = {{16{selHalf[15]}}, selHalf};
      2'b10:   loadVal = {{24{selByte[7]}}, selByte};
      default: loadVal = {24'h0, selByte};
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      readyR    <= 1'b0;
      errorR    <= 1'b0;
      readDataR <= 32'h0;
    end else if (nextState == ST_RESP) begin
      readyR    <= 1'b1;
      errorR    <= effErr;
      readDataR <= (effRd && !effErr) ? loadVal : 32'h0;
    end else begin
      readyR    <= 1'b0;
      errorR    <= 1'b0;
      readDataR <= 32'h0;
    end
  end

  // ---------------------------------------------------------------- store path
  // Committed on the edge that ends RESP, so a reset during WAIT drops the store.
  logic [AW-1:0] wrIdx;
  logic [31:0]   oldWord;
  logic [31:0]   newWord;

  assign wrIdx   = reqAddr[AW+1:2];
  assign oldWord = mem[wrIdx];

  always_comb begin
    newWord = oldWord;
    case (reqSize)
      2'b00:   newWord = reqWdata;
      2'b01:   newWord[{reqAddr[1], 4'b0000} +: 16] = reqWdata[15:0];
      default: newWord[{reqAddr[1:0], 3'b000} +: 8] = reqWdata[7:0];
    endcase
  end

  always_ff @(posedge Clk) begin
    if (state == ST_RESP && reqWr && !errorR) mem[wrIdx] <= newWord;
  end

  assign bus.Ready    = readyR;
  assign bus.Error    = errorR;
  assign bus.ReadData = readDataR;
  assign bus.Busy     = busy;
endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : self-checking bench for data_mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
// Ports   : none; drives Clk/reset and two interface instances.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_data_mem_responder;
  logic Clk = 1'b0;
  logic reset;

  always #5 Clk = ~Clk;

  data_mem_responder_if busA ();
  data_mem_responder_if busB ();

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dutA (
    .Clk   (Clk),
    .reset (reset),
    .bus   (busA)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dutB (
    .Clk   (Clk),
    .reset (reset),
    .bus   (busB)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chkData;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic driveA(input logic rd, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    busA.MemRead   = rd;
    busA.MemWrite  = wr;
    busA.DMControl = size;
    busA.Address   = addr;
    busA.WriteData = wdata;
  endtask

  task automatic driveB(input logic rd, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    busB.MemRead   = rd;
    busB.MemWrite  = wr;
    busB.DMControl = size;
    busB.Address   = addr;
    busB.WriteData = wdata;
  endtask

  // One complete request on instance A: returns the response, the cycle on
  // which Ready appeared (counted from the accepting edge, -1 if never), the
  // number of Busy cycles, and whether the cycle after Ready is fully quiet.
  task automatic runReqA(input logic rd, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output logic err,
                         output int lat, output int busyCnt, output logic tailOk);
    lat     = -1;
    busyCnt = 0;
    data    = 32'h0;
    err     = 1'b0;
    @(negedge Clk);
    driveA(rd, wr, size, addr, wdata);
    @(posedge Clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (busA.Busy) busyCnt++;
      if (busA.Ready) begin
        lat  = c;
        data = busA.ReadData;
        err  = busA.Error;
        break;
      end
    end
    driveA(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge Clk);
    tailOk = !busA.Ready && !busA.Busy && !busA.Error && (busA.ReadData == 32'h0);
  endtask

  initial begin
    logic [31:0] data;
    logic        err;
    int          lat;
    int          busyCnt;
    logic        tailOk;

    //            name       rd    wr    size   addr          wdata          chk   expData        expErr
    vecs[0]  = '{"sw10",    1'b0, 1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{"lw10",    1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{"sw20",    1'b0, 1'b1, 2'b00, 32'h0000_0020, 32'h80F1_7F02, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{"lb21",    1'b1, 1'b0, 2'b10, 32'h0000_0021, 32'h0,         1'b1, 32'h0000_007F, 1'b0};
    vecs[4]  = '{"lb22",    1'b1, 1'b0, 2'b10, 32'h0000_0022, 32'h0,         1'b1, 32'hFFFF_FFF1, 1'b0};
    vecs[5]  = '{"lbu23",   1'b1, 1'b0, 2'b11, 32'h0000_0023, 32'h0,         1'b1, 32'h0000_0080, 1'b0};
    vecs[6]  = '{"lh22",    1'b1, 1'b0, 2'b01, 32'h0000_0022, 32'h0,         1'b1, 32'hFFFF_80F1, 1'b0};
    vecs[7]  = '{"sb20",    1'b0, 1'b1, 2'b10, 32'h0000_0020, 32'h1234_56AA, 1'b0, 32'h0000_0000, 1'b0};
    vecs[8]  = '{"lw20",    1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0,         1'b1, 32'h80F1_7FAA, 1'b0};
    vecs[9]  = '{"sw30",    1'b0, 1'b1, 2'b00, 32'h0000_0030, 32'h1122_3344, 1'b0, 32'h0000_0000, 1'b0};
    vecs[10] = '{"sh32",    1'b0, 1'b1, 2'b01, 32'h0000_0032, 32'hABCD_8765, 1'b0, 32'h0000_0000, 1'b0};
    vecs[11] = '{"sbu31",   1'b0, 1'b1, 2'b11, 32'h0000_0031, 32'h0000_0099, 1'b0, 32'h0000_0000, 1'b0};
    vecs[12] = '{"lw30",    1'b1, 1'b0, 2'b00, 32'h0000_0030, 32'h0,         1'b1, 32'h8765_9944, 1'b0};
    vecs[13] = '{"lh30",    1'b1, 1'b0, 2'b01, 32'h0000_0030, 32'h0,         1'b1, 32'hFFFF_9944, 1'b0};
    vecs[14] = '{"sw00",    1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 32'h0000_0000, 1'b0};
    vecs[15] = '{"sw08",    1'b0, 1'b1, 2'b00, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[16] = '{"elw22",   1'b1, 1'b0, 2'b00, 32'h0000_0022, 32'h0,         1'b1, 32'h0000_0000, 1'b1};
    vecs[17] = '{"lw20b",   1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0,         1'b1, 32'h80F1_7FAA, 1'b0};
    vecs[18] = '{"esh11",   1'b0, 1'b1, 2'b01, 32'h0000_0011, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b1};
    vecs[19] = '{"lw10b",   1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[20] = '{"esw1000", 1'b0, 1'b1, 2'b00, 32'h0000_1000, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
    vecs[21] = '{"elw1000", 1'b1, 1'b0, 2'b00, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_0000, 1'b1};
    vecs[22] = '{"lw00",    1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0};
    vecs[23] = '{"erw10",   1'b1, 1'b1, 2'b00, 32'h0000_0010, 32'h1111_1111, 1'b1, 32'h0000_0000, 1'b1};
    vecs[24] = '{"lw10c",   1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[25] = '{"elh21",   1'b1, 1'b0, 2'b01, 32'h0000_0021, 32'h0,         1'b1, 32'h0000_0000, 1'b1};

    // ------------------------------------------------ reset state
    reset = 1'b0;
    driveA(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    driveB(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #12;
    check("rstA_flags", 32'({busA.Ready, busA.Busy, busA.Error}), 32'h0);
    check("rstA_data",  busA.ReadData, 32'h0);
    check("rstB_flags", 32'({busB.Ready, busB.Busy, busB.Error}), 32'h0);
    check("rstB_data",  busB.ReadData, 32'h0);
    @(negedge Clk);
    reset = 1'b1;

    // ------------------------------------------------ table-driven requests, WAIT_CYCLES=2
    for (int i = 0; i < NVEC; i++) begin
      runReqA(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
              data, err, lat, busyCnt, tailOk);
      check({vecs[i].name, "_lat"},  32'(lat), 32'd3);
      check({vecs[i].name, "_busy"}, 32'(busyCnt), 32'd3);
      check({vecs[i].name, "_tail"}, 32'(tailOk), 32'd1);
      check({vecs[i].name, "_err"},  32'(err), 32'(vecs[i].expErr));
      if (vecs[i].chkData) check({vecs[i].name, "_data"}, data, vecs[i].expData);
    end

    // ------------------------------------------------ reset during WAIT drops the store
    @(negedge Clk);
    driveA(1'b0, 1'b1, 2'b00, 32'h0000_0008, 32'h1234_5678);
    @(posedge Clk);
    @(negedge Clk);
    check("midrst_busy_before", 32'(busA.Busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midrst_flags", 32'({busA.Ready, busA.Busy, busA.Error}), 32'h0);
    check("midrst_data",  busA.ReadData, 32'h0);
    driveA(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    check("midrst_idle", 32'(busA.Busy), 32'd0);
    runReqA(1'b1, 1'b0, 2'b00, 32'h0000_0008, 32'h0, data, err, lat, busyCnt, tailOk);
    check("midrst_lw08_lat",  32'(lat), 32'd3);
    check("midrst_lw08_data", data, 32'h0);
    check("midrst_lw08_err",  32'(err), 32'd0);

    // ------------------------------------------------ inputs changing while busy
    @(negedge Clk);
    driveA(1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    driveA(1'b0, 1'b0, 2'b00, 32'h0000_0020, 32'h0);   // address toggled, request dropped
    @(negedge Clk);
    check("chg_wait_rdy", 32'(busA.Ready), 32'd0);
    driveA(1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0);   // new request presented into RESP
    @(negedge Clk);
    check("chg_resp_rdy",  32'(busA.Ready), 32'd1);
    check("chg_resp_data", busA.ReadData, 32'hDEAD_BEEF);
    check("chg_resp_err",  32'(busA.Error), 32'd0);
    @(negedge Clk);
    check("chg_after_busy", 32'(busA.Busy), 32'd0);
    check("chg_after_rdy",  32'(busA.Ready), 32'd0);
    driveA(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge Clk);
    check("chg_quiet_busy", 32'(busA.Busy), 32'd0);

    // ------------------------------------------------ WAIT_CYCLES=0, back-to-back
    @(negedge Clk);
    driveB(1'b0, 1'b1, 2'b00, 32'h0000_0004, 32'hCAFE_F00D);
    @(posedge Clk);
    @(negedge Clk);
    check("w0_st_rdy",  32'(busB.Ready), 32'd1);
    check("w0_st_busy", 32'(busB.Busy), 32'd1);
    check("w0_st_err",  32'(busB.Error), 32'd0);
    driveB(1'b1, 1'b0, 2'b00, 32'h0000_0004, 32'h0);
    @(negedge Clk);
    check("w0_gap1_rdy",  32'(busB.Ready), 32'd0);
    check("w0_gap1_busy", 32'(busB.Busy), 32'd0);
    @(negedge Clk);
    check("w0_ld1_rdy",  32'(busB.Ready), 32'd1);
    check("w0_ld1_data", busB.ReadData, 32'hCAFE_F00D);
    @(negedge Clk);
    check("w0_gap2_rdy",  32'(busB.Ready), 32'd0);
    check("w0_gap2_data", busB.ReadData, 32'h0);
    @(negedge Clk);
    check("w0_ld2_rdy",  32'(busB.Ready), 32'd1);
    check("w0_ld2_data", busB.ReadData, 32'hCAFE_F00D);
    driveB(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge Clk);
    check("w0_end_rdy",  32'(busB.Ready), 32'd0);
    check("w0_end_busy", 32'(busB.Busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
